// File: rtl/melody_sequencer.sv
// Programmable melody player: a register table of NUM_MELODIES tunes, played one at a time
// on the slowClken time base with slot-priority pre-emption, per-slot looping and rests.
module melody_sequencer #(
  parameter int unsigned NUM_MELODIES = 4,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned NOTE_W       = 4,
  parameter int unsigned DUR_W        = 3,
  parameter int unsigned REST_NOTE    = 13
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            slowClken,
  input  logic [NUM_MELODIES-1:0]         trig,
  input  logic [NUM_MELODIES-1:0]         loop_en,
  input  logic                            stop,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_MELODIES)-1:0] wr_mel,
  input  logic [$clog2(MAX_LEN)-1:0]      wr_idx,
  input  logic [NOTE_W-1:0]               wr_note,
  input  logic [DUR_W-1:0]                wr_dur,
  input  logic                            wr_last,
  output logic [NOTE_W-1:0]               note_num,
  output logic                            enable_sound,
  output logic                            busy,
  output logic [$clog2(NUM_MELODIES)-1:0] cur_mel,
  output logic                            done
);

  localparam int unsigned MW = $clog2(NUM_MELODIES);
  localparam int unsigned IW = $clog2(MAX_LEN);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  logic [NOTE_W-1:0] note_q [NUM_MELODIES][MAX_LEN];
  logic [DUR_W-1:0]  dur_q  [NUM_MELODIES][MAX_LEN];
  logic              last_q [NUM_MELODIES][MAX_LEN];

  state_e            state_q;
  logic [MW-1:0]     mel_q;
  logic [IW-1:0]     idx_q;
  logic [DUR_W-1:0]  cnt_q;
  logic              done_q;

  logic [NOTE_W-1:0] cur_note;
  logic              is_last;
  logic [IW-1:0]     nxt_idx;
  logic              trig_any;
  logic [MW-1:0]     trig_sel;
  logic              preempt;

  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int m = 0; m < NUM_MELODIES; m++) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          note_q[m][i] <= NOTE_W'(REST_NOTE);
          dur_q[m][i]  <= DUR_W'(1);
          last_q[m][i] <= 1'b1;
        end
      end
    end else if (wr_en) begin
      note_q[wr_mel][wr_idx] <= wr_note;
      dur_q[wr_mel][wr_idx]  <= wr_dur;
      last_q[wr_mel][wr_idx] <= wr_last;
    end
  end

  // Lowest set trig bit wins; it pre-empts only a strictly lower-priority slot.
  always_comb begin
    trig_any = |trig;
    trig_sel = '0;
    for (int j = NUM_MELODIES - 1; j >= 0; j--) begin
      if (trig[j]) trig_sel = MW'(j);
    end
  end

  assign preempt  = trig_any && (trig_sel < mel_q);
  assign cur_note = note_q[mel_q][idx_q];
  assign nxt_idx  = idx_q + IW'(1);
  assign is_last  = last_q[mel_q][idx_q] || (idx_q == IW'(MAX_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mel_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trig_any) begin
            state_q <= StPlay;
            mel_q   <= trig_sel;
            idx_q   <= '0;
            cnt_q   <= eff_dur(dur_q[trig_sel][0]);
          end
        end
        StPlay: begin
          if (stop) begin
            state_q <= StIdle;
            mel_q   <= '0;
          end else if (preempt) begin
            mel_q <= trig_sel;
            idx_q <= '0;
            cnt_q <= eff_dur(dur_q[trig_sel][0]);
          end else if (slowClken) begin
            if (cnt_q > DUR_W'(1)) begin
              cnt_q <= cnt_q - DUR_W'(1);
            end else if (!is_last) begin
              idx_q <= nxt_idx;
              cnt_q <= eff_dur(dur_q[mel_q][nxt_idx]);
            end else if (loop_en[mel_q]) begin
              idx_q <= '0;
              cnt_q <= eff_dur(dur_q[mel_q][0]);
            end else begin
              state_q <= StIdle;
              mel_q   <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy         = (state_q == StPlay);
  assign note_num     = busy ? cur_note : NOTE_W'(REST_NOTE);
  assign enable_sound = busy && (cur_note != NOTE_W'(REST_NOTE));
  assign cur_mel      = mel_q;
  assign done         = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: hand-computed expectations checked with immediate asserts.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       reset, slowClken, stop, wr_en, wr_last;
  logic [3:0] trig, loop_en, wr_idx, wr_note, note_num;
  logic [1:0] wr_mel, cur_mel;
  logic [2:0] wr_dur;
  logic       enable_sound, busy, done;

  int checks = 0;
  int errors = 0;

  melody_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .slowClken    (slowClken),
    .trig         (trig),
    .loop_en      (loop_en),
    .stop         (stop),
    .wr_en        (wr_en),
    .wr_mel       (wr_mel),
    .wr_idx       (wr_idx),
    .wr_note      (wr_note),
    .wr_dur       (wr_dur),
    .wr_last      (wr_last),
    .note_num     (note_num),
    .enable_sound (enable_sound),
    .busy         (busy),
    .cur_mel      (cur_mel),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slow_tick();
    slowClken = 1'b1;
    tick();
    slowClken = 1'b0;
  endtask

  task automatic write(input int mel, input int idx, input int note, input int dur,
                       input logic last);
    wr_en   = 1'b1;
    wr_mel  = 2'(mel);
    wr_idx  = 4'(idx);
    wr_note = 4'(note);
    wr_dur  = 3'(dur);
    wr_last = last;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_trig(input logic [3:0] t);
    trig = t;
    tick();
    trig = '0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; slowClken = 1'b0; stop = 1'b0; trig = '0; loop_en = '0;
    wr_en = 1'b0; wr_mel = '0; wr_idx = '0; wr_note = '0; wr_dur = '0; wr_last = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_note", int'(note_num), 13);
    chk("rst_en", int'(enable_sound), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mel", int'(cur_mel), 0);
    chk("rst_done", int'(done), 0);

    // Basic play on slot 1 with a live write to the sounding entry.
    write(1, 0, 3, 2, 1'b0);
    write(1, 1, 5, 1, 1'b0);
    write(1, 2, 7, 1, 1'b1);
    pulse_trig(4'b0010);
    chk("s1_note3", int'(note_num), 3);
    chk("s1_busy", int'(busy), 1);
    chk("s1_mel", int'(cur_mel), 1);
    chk("s1_en", int'(enable_sound), 1);
    slow_tick();
    chk("s1_hold3", int'(note_num), 3);
    write(1, 0, 8, 5, 1'b0);
    chk("s5_live8", int'(note_num), 8);
    slow_tick();
    chk("s1_note5", int'(note_num), 5);
    slow_tick();
    chk("s1_note7", int'(note_num), 7);
    slow_tick();
    chk("s1_done", int'(done), 1);
    chk("s1_idle_busy", int'(busy), 0);
    chk("s1_idle_note", int'(note_num), 13);
    chk("s1_idle_mel", int'(cur_mel), 0);
    tick();
    chk("s1_done_once", int'(done), 0);

    // Loop, rest and zero duration on slot 2.
    write(2, 0, 4, 1, 1'b0);
    write(2, 1, 13, 0, 1'b0);
    write(2, 2, 6, 1, 1'b1);
    loop_en = 4'b0100;
    pulse_trig(4'b0100);
    chk("s2_note4", int'(note_num), 4);
    chk("s2_mel", int'(cur_mel), 2);
    slow_tick();
    chk("s2_rest", int'(note_num), 13);
    chk("s2_rest_en", int'(enable_sound), 0);
    chk("s2_rest_busy", int'(busy), 1);
    slow_tick();
    chk("s2_note6", int'(note_num), 6);
    chk("s2_done_a", int'(done), 0);
    slow_tick();
    chk("s2_loop4", int'(note_num), 4);
    chk("s2_done_b", int'(done), 0);
    chk("s2_busy", int'(busy), 1);

    // Priority: a lower-priority trigger is ignored, a higher one pre-empts.
    pulse_trig(4'b1000);
    chk("s3_ign_mel", int'(cur_mel), 2);
    chk("s3_ign_note", int'(note_num), 4);
    pulse_trig(4'b0100);
    slow_tick();
    chk("s3_noretrig", int'(note_num), 13);
    write(0, 0, 9, 2, 1'b1);
    pulse_trig(4'b0001);
    chk("s3_pre_mel", int'(cur_mel), 0);
    chk("s3_pre_note", int'(note_num), 9);
    slow_tick();
    chk("s3_hold9", int'(note_num), 9);
    chk("s3_nodone", int'(done), 0);
    slow_tick();
    chk("s3_done", int'(done), 1);
    chk("s3_idle", int'(busy), 0);

    // Stop beats a simultaneous trigger; reset mid-play clears the table.
    pulse_trig(4'b0100);
    chk("s4_play", int'(busy), 1);
    stop = 1'b1;
    trig = 4'b0001;
    tick();
    stop = 1'b0;
    trig = '0;
    chk("s4_stop_busy", int'(busy), 0);
    chk("s4_stop_done", int'(done), 0);
    chk("s4_stop_note", int'(note_num), 13);
    tick();
    chk("s4_stop_done2", int'(done), 0);
    pulse_trig(4'b0100);
    slow_tick();
    chk("s4_midplay", int'(cur_mel), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s4_rst_busy", int'(busy), 0);
    chk("s4_rst_note", int'(note_num), 13);
    chk("s4_rst_en", int'(enable_sound), 0);
    chk("s4_rst_done", int'(done), 0);
    loop_en = '0;
    pulse_trig(4'b0010);
    chk("s4_clr_busy", int'(busy), 1);
    chk("s4_clr_note", int'(note_num), 13);
    chk("s4_clr_en", int'(enable_sound), 0);
    slow_tick();
    chk("s4_clr_done", int'(done), 1);

    // Full-length melody with no last flag ends after the final table entry.
    for (int i = 0; i < 16; i++) write(3, i, (i % 12) + 1, 1, 1'b0);
    pulse_trig(4'b1000);
    for (int i = 0; i < 16; i++) begin
      chk("s6_note", int'(note_num), (i % 12) + 1);
      slow_tick();
      if (i < 15) chk("s6_busy", int'(busy), 1);
    end
    chk("s6_done", int'(done), 1);
    chk("s6_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
